pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-stage program-counter generator, successor to the single-source PC register. Holds the fetch PC and selects the next PC from trap vector, execute-stage redirect, stall hold, branch-target-buffer prediction or sequential increment, with a fixed priority. Sits at the head of IF; its `pc` drives instruction-memory address and is carried down the pipeline with the prediction so EX can detect mispredicts.

## Interface
- `XLEN`, 32: PC width in bits.
- `RESET_VEC`, 32'h0000_0000: PC value loaded by reset.
- `BTB_DEPTH`, 16: BTB entries; power of two, ≥2; index width `IW = log2(BTB_DEPTH)`.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold current PC (fetch not accepted).
- `trap_valid` in 1: trap/exception entry this cycle.
- `trap_pc` in XLEN: trap handler address.
- `redirect_valid` in 1: EX-resolved redirect (mispredict or jump).
- `redirect_pc` in XLEN: redirect target.
- `upd_valid` in 1: BTB training from EX.
- `upd_pc` in XLEN: PC of resolved control-flow instruction.
- `upd_target` in XLEN: its resolved target.
- `upd_taken` in 1: resolved direction.
- `pc` out XLEN: current fetch PC.
- `pc_valid` out 1: PC is meaningful.
- `pred_taken` out 1: BTB hit for `pc` (combinational from `pc` and BTB state).
- `pred_target` out XLEN: predicted target for `pc`; 0 when no hit.
- `misalign` out 1: the current `pc` came from a trap/redirect target with bits [1:0] ≠ 0.

## Operation
- Next-PC priority, evaluated each rising edge: `rst` > `trap_valid` > `redirect_valid` > `stall` > `pred_taken` > sequential.
- Trap/redirect: `pc <= target & ~3`; `misalign <= |target[1:0]`. Both override `stall`, since a flush supersedes a hold.
- Stall: `pc`, `misalign` unchanged.
- Predict: `pc <= pred_target`; `misalign <= 0`.
- Sequential: `pc <= pc + 4`, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0); `misalign <= 0`.
- Reset: `pc = RESET_VEC`, `pc_valid = 0`, `misalign = 0`, all BTB valid bits cleared in the same edge. `pc_valid` becomes 1 on the first edge with `rst` low and stays 1. Reset mid-operation discards any pending redirect or update.
- BTB (only when compiled in): direct-mapped; index = `pc[IW+1:2]`; tag = `pc[XLEN-1:IW+2]`; each entry holds valid, tag and target[XLEN-1:2].
  - Hit = valid and tag match.
- BTB update on an edge with `upd_valid`:
  - taken → write valid/tag/target at `upd_pc`'s index, overwriting any entry there;
  - not-taken with tag match → clear valid;
  - not-taken without match → no change.
- Update and lookup at the same index in the same cycle: the lookup uses the pre-update contents.
- Update is not blocked by `stall`, `trap_valid` or `redirect_valid`.

## Timing
- One-cycle latency: a selection made at edge N appears on `pc` after edge N.
- A redirect asserted in cycle N yields `pc = redirect_pc` in cycle N+1.
- BTB write at edge N is visible to the lookup from cycle N+1.
- `pred_taken`/`pred_target` are combinational from registered state; there is no combinational path from any input to any output.

## Configuration
- `PC_GEN_BTB_EN` defined: BTB storage and prediction present as above.
- `PC_GEN_BTB_EN` undefined: no BTB storage; `pred_taken = 0`, `pred_target = 0`; `upd_*` ignored; next PC is trap/redirect/stall/sequential only.

## Structure
- Shared defines file: next-PC select encodings (`NPC_TRAP`, `NPC_REDIRECT`, `NPC_HOLD`, `NPC_PRED`, `NPC_SEQ`) and the instruction-step constant 4, extending the existing `NEW_PC`/`PC_PLUS4` defines.
- One sub-module, `pc_btb`: storage, lookup and update logic, parametrised by `XLEN` and `BTB_DEPTH`, instantiated only under `PC_GEN_BTB_EN`. `pc_gen` holds the PC register and priority mux.

## Test plan
- Reset release, `RESET_VEC=0x100`, no other inputs → `pc` 0x100, 0x104, 0x108; `pc_valid` 0 during reset, 1 after.
- Stall and redirect together: `stall=1` with `redirect_valid=1, redirect_pc=0x2000` → next `pc=0x2000`. `stall=1` alone → `pc` holds for 3 cycles.
- Trap and redirect same cycle: `trap_pc=0x80`, `redirect_pc=0x400` → `pc=0x80`. Then `redirect_pc=0x402` → `pc=0x400`, `misalign=1`. Next sequential cycle → `misalign=0`.
- Wrap: `pc=0xFFFF_FFFC`, sequential → `pc=0x0`.
- BTB train and predict: update `upd_pc=0x10, upd_target=0x40, taken`; later `pc=0x10` → `pred_taken=1`, next `pc=0x40`. Not-taken update at 0x10 → the following fetch of 0x10 goes to 0x14.
- BTB alias and config: with `BTB_DEPTH=16`, train 0x10 then 0x50 (same index) → 0x10 misses. With `PC_GEN_BTB_EN` undefined, the same training gives `pred_taken=0` throughout.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen shared defines: next-PC select encodings and instruction step.
// Extends the legacy NEW_PC / PC_PLUS4 selects with trap, hold and predict.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    NPC_TRAP     = 3'd0,
    NPC_REDIRECT = 3'd1,
    NPC_HOLD     = 3'd2,
    NPC_PRED     = 3'd3,
    NPC_SEQ      = 3'd4
  } npc_sel_e;

  // Legacy names from the single-source PC register.
  localparam npc_sel_e NEW_PC   = NPC_REDIRECT;
  localparam npc_sel_e PC_PLUS4 = NPC_SEQ;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_gen_btb.sv
// pc_btb: direct-mapped branch target buffer for the fetch PC generator.
// Lookup is combinational from registered state; updates land on the edge.
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic            hit,
  output logic [XLEN-1:0] target
);

  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IW - 2;

  logic [BTB_DEPTH-1:0] r_vld;
  logic [TW-1:0]        r_tag [BTB_DEPTH];
  logic [XLEN-3:0]      r_tgt [BTB_DEPTH];

  logic [IW-1:0] w_li;
  logic [TW-1:0] w_lt;
  logic [IW-1:0] w_ui;
  logic [TW-1:0] w_ut;
  logic          w_umatch;

  assign w_li = lk_pc[IW+1:2];
  assign w_lt = lk_pc[XLEN-1:IW+2];
  assign w_ui = upd_pc[IW+1:2];
  assign w_ut = upd_pc[XLEN-1:IW+2];

  assign w_umatch = r_vld[w_ui] && (r_tag[w_ui] == w_ut);

  // Lookup: a hit needs a valid entry with matching tag.
  always_comb begin
    hit    = r_vld[w_li] && (r_tag[w_li] == w_lt);
    target = '0;
    if (hit) target = {r_tgt[w_li], 2'b00};
  end

  // Training: taken allocates/overwrites, not-taken on match evicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        r_vld[w_ui] <= 1'b1;
        r_tag[w_ui] <= w_ut;
        r_tgt[w_ui] <= upd_target[XLEN-1:2];
      end else if (w_umatch) begin
        r_vld[w_ui] <= 1'b0;
      end
    end
  end

  logic w_unused_lsb;
  assign w_unused_lsb = ^{lk_pc[1:0], upd_pc[1:0], upd_target[1:0]};

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with trap/redirect/hold/predict/seq priority.
// Define PC_GEN_BTB_EN to build in the pc_btb predictor.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            misalign
);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_mis;

  npc_sel_e        w_sel;
  logic [XLEN-1:0] w_npc;
  logic            w_nmis;
  logic [XLEN-1:0] w_flush_pc;
  logic            w_hit;
  logic [XLEN-1:0] w_ptgt;

`ifdef PC_GEN_BTB_EN
  pc_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_pc      (r_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .hit        (w_hit),
    .target     (w_ptgt)
  );
`else
  assign w_hit  = 1'b0;
  assign w_ptgt = '0;

  logic        w_unused_upd;
  logic [31:0] w_unused_cfg;
  assign w_unused_upd = ^{upd_valid, upd_pc, upd_target, upd_taken};
  assign w_unused_cfg = BTB_DEPTH;
`endif

  assign w_flush_pc = trap_valid ? trap_pc : redirect_pc;

  // Fixed-priority next-PC source select.
  always_comb begin
    w_sel = NPC_SEQ;
    if (trap_valid)          w_sel = NPC_TRAP;
    else if (redirect_valid) w_sel = NPC_REDIRECT;
    else if (stall)          w_sel = NPC_HOLD;
    else if (w_hit)          w_sel = NPC_PRED;
  end

  // Next PC and misalign flag for the chosen source.
  always_comb begin
    w_npc  = r_pc + XLEN'(PC_STEP);
    w_nmis = 1'b0;
    unique case (w_sel)
      NPC_TRAP, NPC_REDIRECT: begin
        w_npc  = {w_flush_pc[XLEN-1:2], 2'b00};
        w_nmis = |w_flush_pc[1:0];
      end
      NPC_HOLD: begin
        w_npc  = r_pc;
        w_nmis = r_mis;
      end
      NPC_PRED: w_npc = w_ptgt;
      default:  ;
    endcase
  end

  // PC register; valid rises on the first edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_VEC;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_pc    <= w_npc;
      r_valid <= 1'b1;
      r_mis   <= w_nmis;
    end
  end

  assign pc          = r_pc;
  assign pc_valid    = r_valid;
  assign misalign    = r_mis;
  assign pred_taken  = w_hit;
  assign pred_target = w_ptgt;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table plus BTB sequences for pc_gen.
// Expectations follow PC_GEN_BTB_EN when the bench is built with it.
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0100),
    .BTB_DEPTH (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .misalign       (misalign)
  );

  typedef struct {
    logic        st;
    logic        tv;
    logic [31:0] tpc;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic        emis;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; trap_valid = 0; trap_pc = '0;
    redirect_valid = 0; redirect_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
  endtask

  task automatic redir(input logic [31:0] a);
    idle();
    redirect_valid = 1; redirect_pc = a;
  endtask

  task automatic train(input logic [31:0] a, input logic [31:0] t,
                       input logic tk);
    upd_valid = 1; upd_pc = a; upd_target = t; upd_taken = tk;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h108, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 32'h108, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 32'h108, 0};
    vecs[3]  = '{1, 0, 0, 1, 32'h2000, 32'h2000, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 32'h2004, 0};
    vecs[5]  = '{0, 1, 32'h80, 1, 32'h400, 32'h80, 0};
    vecs[6]  = '{0, 0, 0, 1, 32'h402, 32'h400, 1};
    vecs[7]  = '{1, 0, 0, 0, 0, 32'h400, 1};
    vecs[8]  = '{0, 0, 0, 0, 0, 32'h404, 0};
    vecs[9]  = '{0, 1, 32'h103, 0, 0, 32'h100, 1};
    vecs[10] = '{0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 32'h0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 32'h4, 0};
    vecs[13] = '{1, 1, 32'h7, 0, 0, 32'h4, 1};

    idle();
    rst = 1;
    tick();
    tick();
    chk("rst_pc", pc, 32'h100);
    chk("rst_valid", {31'b0, pc_valid}, 0);
    chk("rst_mis", {31'b0, misalign}, 0);

    rst = 0;
    tick();
    chk("seq1_pc", pc, 32'h104);
    chk("seq1_valid", {31'b0, pc_valid}, 1);
    tick();
    chk("seq2_pc", pc, 32'h108);

    for (int i = 0; i < 14; i++) begin
      idle();
      stall = vecs[i].st;
      trap_valid = vecs[i].tv; trap_pc = vecs[i].tpc;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
      chk($sformatf("vec%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].emis});
      chk($sformatf("vec%0d_valid", i), {31'b0, pc_valid}, 1);
      chk($sformatf("vec%0d_pred", i), {31'b0, pred_taken}, 0);
    end

    // Train 0x10 -> 0x40 alongside a redirect, then walk into it.
    redir(32'h8);
    train(32'h10, 32'h40, 1);
    tick();
    idle();
    chk("btb_pc8", pc, 32'h8);
    tick();
    chk("btb_pcC_pred", {31'b0, pred_taken}, 0);
    tick();
    chk("btb_pc10", pc, 32'h10);
    chk("btb_hit", {31'b0, pred_taken}, {31'b0, BTB});
    chk("btb_tgt", pred_target, BTB ? 32'h40 : 32'h0);
    tick();
    chk("btb_next", pc, BTB ? 32'h40 : 32'h14);
    chk("btb_next_mis", {31'b0, misalign}, 0);

    // Not-taken update in the cycle 0x10 is fetched: lookup sees old entry.
    redir(32'h10);
    tick();
    idle();
    train(32'h10, 32'h40, 0);
    chk("nt_same_hit", {31'b0, pred_taken}, {31'b0, BTB});
    tick();
    idle();
    chk("nt_same_next", pc, BTB ? 32'h40 : 32'h14);
    redir(32'h10);
    tick();
    idle();
    chk("nt_evict_hit", {31'b0, pred_taken}, 0);
    tick();
    chk("nt_evict_next", pc, 32'h14);

    // Alias: 0x50 shares index with 0x10 and overwrites it.
    idle();
    train(32'h10, 32'h40, 1);
    tick();
    idle();
    train(32'h50, 32'h80, 1);
    stall = 1;
    tick();
    redir(32'h50);
    tick();
    idle();
    chk("alias_hit50", {31'b0, pred_taken}, {31'b0, BTB});
    tick();
    chk("alias_next50", pc, BTB ? 32'h80 : 32'h54);
    redir(32'h10);
    tick();
    idle();
    chk("alias_miss10", {31'b0, pred_taken}, 0);
    tick();
    chk("alias_next10", pc, 32'h14);

    // Reset with a pending update and redirect discards both.
    idle();
    train(32'h10, 32'h40, 1);
    tick();
    redir(32'h300);
    train(32'h20, 32'h60, 1);
    rst = 1;
    tick();
    rst = 0;
    idle();
    chk("mid_rst_pc", pc, 32'h100);
    chk("mid_rst_valid", {31'b0, pc_valid}, 0);
    redir(32'h10);
    tick();
    idle();
    chk("mid_rst_pc10", pc, 32'h10);
    chk("mid_rst_hit10", {31'b0, pred_taken}, 0);
    redir(32'h20);
    tick();
    idle();
    chk("mid_rst_hit20", {31'b0, pred_taken}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
